blowfish128_arbiter: RTL

- Round-robin scheduler that shares one blowfish128 engine (core + skeygen + ffunc top) between two block requesters.
- Accepts one 128-bit job at a time and drives the engine's Enable/Encrypt/plainText.
- Waits for cipherReady, then returns the result to the owning requester with backpressure.
- Guards against a hung engine with a timeout, and inserts an Enable-low gap between jobs so the engine re-arms its key schedule.

---
 rtl/blowfish128_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/blowfish128_arbiter.sv
// blowfish128_arbiter: round-robin sharing of one blowfish128 engine between two block requesters
module blowfish128_arbiter #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GAP_CYCLES     = 2
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         req0_valid,
    input  logic         req0_encrypt,
    input  logic [127:0] req0_data,
    output logic         req0_ready,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [127:0] rsp0_data,
    output logic         rsp0_err,
    input  logic         req1_valid,
    input  logic         req1_encrypt,
    input  logic [127:0] req1_data,
    output logic         req1_ready,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [127:0] rsp1_data,
    output logic         rsp1_err,
    output logic         eng_enable,
    output logic         eng_encrypt,
    output logic [127:0] eng_plainText,
    input  logic [127:0] eng_cipherText,
    input  logic         eng_cipherReady,
    output logic         busy,
    output logic         grant_id
);
    typedef enum logic [1:0] {IDLE, RUN, RESP, GAP} state_t;

    state_t       state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [7:0]   gap_q, gap_d;
    logic [127:0] pt_q, pt_d, data_q, data_d;
    logic         enc_q, enc_d, err_q, err_d, grant_q, grant_d, last_q, last_d;
    logic         pick, take, rsp_ready;

    // Next-state logic: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        pick      = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        take      = (state_q == IDLE) && (req0_valid || req1_valid);
        rsp_ready = grant_q ? rsp1_ready : rsp0_ready;
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        pt_d      = pt_q;
        enc_d     = enc_q;
        data_d    = data_q;
        err_d     = err_q;
        grant_d   = grant_q;
        last_d    = last_q;
        unique case (state_q)
            IDLE: if (take) begin
                state_d = RUN;
                grant_d = pick;
                last_d  = pick;
                pt_d    = pick ? req1_data : req0_data;
                enc_d   = pick ? req1_encrypt : req0_encrypt;
                cnt_d   = '0;
            end
            RUN: begin
                cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                if (eng_cipherReady) begin
                    state_d = RESP;
                    data_d  = eng_cipherText;
                    err_d   = 1'b0;
                end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_d = RESP;
                    data_d  = '0;
                    err_d   = 1'b1;
                end
            end
            RESP: if (rsp_ready) begin
                state_d = GAP;
                gap_d   = '0;
            end
            GAP: begin
                gap_d   = gap_q + 8'd1;
                state_d = (gap_q == 8'(GAP_CYCLES - 1)) ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and job registers; reset favours requester 0 on the first tie
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            pt_q    <= '0;
            enc_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            pt_q    <= pt_d;
            enc_q   <= enc_d;
            data_q  <= data_d;
            err_q   <= err_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign req0_ready    = ~Rst & take & ~pick;
    assign req1_ready    = ~Rst & take & pick;
    assign rsp0_valid    = (state_q == RESP) & ~grant_q;
    assign rsp1_valid    = (state_q == RESP) & grant_q;
    assign rsp0_data     = data_q;
    assign rsp1_data     = data_q;
    assign rsp0_err      = err_q;
    assign rsp1_err      = err_q;
    assign eng_enable    = (state_q == RUN);
    assign eng_encrypt   = enc_q;
    assign eng_plainText = pt_q;
    assign busy          = (state_q != IDLE);
    assign grant_id      = grant_q;
endmodule
